// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - op handshake between the sequencer and the accumulator ALU
//
// Signals:
//   Data      operand driven to the accumulator (DATA_W)
//   Function  function code: 00 add, 01 mul, 10 shl, 11 hold
//   OpValid   Data/Function carry a live op
//   OpReady   accumulator accepts the op this cycle
//   Result    accumulator register output (RES_W)
// Modports: master = sequencer side, slave = accumulator side.

interface alu_op_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int RES_W  = 8
);
    logic [DATA_W-1:0] Data;
    logic [1:0]        Function;
    logic              OpValid;
    logic              OpReady;
    logic [RES_W-1:0]  Result;

    modport master (
        output Data,
        output Function,
        output OpValid,
        input  OpReady,
        input  Result
    );

    modport slave (
        input  Data,
        input  Function,
        input  OpValid,
        output OpReady,
        output Result
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issues a small (Function, Data) program to an accumulator ALU
//
// Holds DEPTH program entries loaded from switch inputs and issues them one per
// valid/ready handshake, capturing the accumulator result after each accepted op.
//
// Ports:
//   Clock       in   rising-edge clock
//   Reset_b     in   asynchronous reset, active HIGH
//   Load        in   write LoadFunc/LoadData into program[LoadAddr] (IDLE only)
//   LoadAddr    in   program write address
//   LoadData    in   operand to store
//   LoadFunc    in   function code to store
//   Count       in   ops to run (0..15, clamped to DEPTH)
//   Start       in   begin a run from entry 0 (IDLE only)
//   Loop        in   present only with ALU_SEQ_LOOP_EN: restart instead of finishing
//   op          if   master side of the op handshake (Data, Function, OpValid, OpReady, Result)
//   LastResult  out  Result captured after the most recent accepted op
//   StepIdx     out  program index of the current/last op
//   Busy        out  high while issuing or waiting
//   Done        out  one-cycle pulse at the end of a run
//
// Optional feature macro: ALU_SEQ_LOOP_EN

module alu_op_sequencer #(
    parameter  int DEPTH  = 8,
    parameter  int DATA_W = 4,
    parameter  int RES_W  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset_b,
    input  logic              Load,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [DATA_W-1:0] LoadData,
    input  logic [1:0]        LoadFunc,
    input  logic [3:0]        Count,
    input  logic              Start,
`ifdef ALU_SEQ_LOOP_EN
    input  logic              Loop,
`endif
    alu_op_sequencer_if.master op,
    output logic [RES_W-1:0]  LastResult,
    output logic [ADDR_W-1:0] StepIdx,
    output logic              Busy,
    output logic              Done
);

    localparam logic [1:0] FUNC_HOLD = 2'b11;

    typedef struct packed {
        logic [1:0]        func;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    entry_t            prog [DEPTH];
    logic [ADDR_W-1:0] last_idx;
    logic [ADDR_W-1:0] start_last;
    logic [ADDR_W-1:0] step_next;
    entry_t            entry0;
    logic              loop_en;

`ifdef ALU_SEQ_LOOP_EN
    assign loop_en = Loop;
`else
    assign loop_en = 1'b0;
`endif

    // Index of the final op for the run being started; Count is clamped to DEPTH.
    // Only meaningful when Count != 0.
    always_comb begin
        if (int'(Count) > DEPTH) begin
            start_last = ADDR_W'(DEPTH - 1);
        end else begin
            start_last = ADDR_W'(Count - 4'd1);
        end
    end

    assign step_next = StepIdx + ADDR_W'(1);

    // A Load to entry 0 in the same cycle as Start must be seen by the first op,
    // so forward the incoming write instead of the stale stored value.
    always_comb begin
        entry0 = prog[0];
        if (Load && (LoadAddr == '0)) begin
            entry0 = '{func: LoadFunc, data: LoadData};
        end
    end

    // Program store: writable only while idle so a run never sees a changing program.
    always_ff @(posedge Clock or posedge Reset_b) begin
        if (Reset_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                prog[i] <= '{func: FUNC_HOLD, data: '0};
            end
        end else if ((state == S_IDLE) && Load) begin
            prog[LoadAddr] <= '{func: LoadFunc, data: LoadData};
        end
    end

    always_ff @(posedge Clock or posedge Reset_b) begin
        if (Reset_b) begin
            state       <= S_IDLE;
            op.Data     <= '0;
            op.Function <= FUNC_HOLD;
            op.OpValid  <= 1'b0;
            LastResult  <= '0;
            StepIdx     <= '0;
            last_idx    <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        if (Count != 4'd0) begin
                            state       <= S_ISSUE;
                            StepIdx     <= '0;
                            last_idx    <= start_last;
                            op.Function <= entry0.func;
                            op.Data     <= entry0.data;
                            op.OpValid  <= 1'b1;
                            Busy        <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            Done  <= 1'b1;
                        end
                    end
                end

                S_ISSUE: begin
                    // Outputs are held untouched until the accumulator accepts.
                    if (op.OpReady) begin
                        state       <= S_WAIT;
                        op.OpValid  <= 1'b0;
                        op.Function <= FUNC_HOLD;
                        op.Data     <= '0;
                    end
                end

                S_WAIT: begin
                    // The accumulator register updated on the accept edge, so
                    // Result already reflects the op just issued.
                    LastResult <= op.Result;
                    if (StepIdx == last_idx) begin
                        if (loop_en) begin
                            state       <= S_ISSUE;
                            StepIdx     <= '0;
                            op.Function <= prog[0].func;
                            op.Data     <= prog[0].data;
                            op.OpValid  <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end
                    end else begin
                        state       <= S_ISSUE;
                        StepIdx     <= step_next;
                        op.Function <= prog[step_next].func;
                        op.Data     <= prog[step_next].data;
                        op.OpValid  <= 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    Done  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer

module tb_alu_op_sequencer;

    logic       Clock;
    logic       Reset_b;
    logic       Load;
    logic [2:0] LoadAddr;
    logic [3:0] LoadData;
    logic [1:0] LoadFunc;
    logic [3:0] Count;
    logic       Start;
    logic       Loop;
    logic       ready;
    logic [7:0] LastResult;
    logic [2:0] StepIdx;
    logic       Busy;
    logic       Done;

    logic [7:0] acc;
    int         accepts;
    int         checks;
    int         errors;

    alu_op_sequencer_if #(.DATA_W(4), .RES_W(8)) op_if ();

    alu_op_sequencer #(.DEPTH(8), .DATA_W(4), .RES_W(8)) dut (
        .Clock      (Clock),
        .Reset_b    (Reset_b),
        .Load       (Load),
        .LoadAddr   (LoadAddr),
        .LoadData   (LoadData),
        .LoadFunc   (LoadFunc),
        .Count      (Count),
        .Start      (Start),
`ifdef ALU_SEQ_LOOP_EN
        .Loop       (Loop),
`endif
        .op         (op_if),
        .LastResult (LastResult),
        .StepIdx    (StepIdx),
        .Busy       (Busy),
        .Done       (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Accumulator register standing in for the ALU side of the handshake.
    assign op_if.OpReady = ready;
    assign op_if.Result  = acc;

    always @(posedge Clock or posedge Reset_b) begin
        if (Reset_b) begin
            acc <= 8'd0;
        end else if (op_if.OpValid && op_if.OpReady) begin
            case (op_if.Function)
                2'b00:   acc <= acc + 8'(op_if.Data);
                2'b01:   acc <= acc * 8'(op_if.Data);
                2'b10:   acc <= acc << op_if.Data;
                default: acc <= acc;
            endcase
            accepts <= accepts + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load_entry(input logic [2:0] a, input logic [1:0] f, input logic [3:0] d);
        Load     = 1'b1;
        LoadAddr = a;
        LoadFunc = f;
        LoadData = d;
        tick();
        Load = 1'b0;
    endtask

    task automatic run_to_done(input int limit, output int cycles);
        cycles = 0;
        while ((cycles < limit) && (Done !== 1'b1)) begin
            tick();
            cycles++;
        end
        check_eq("done_within_limit", 32'(Done), 32'd1);
    endtask

    int cyc;
    int acc_base;
    bit seen;

    initial begin
        checks   = 0;
        errors   = 0;
        accepts  = 0;
        Reset_b  = 1'b0;
        Load     = 1'b0;
        LoadAddr = '0;
        LoadData = '0;
        LoadFunc = '0;
        Count    = '0;
        Start    = 1'b0;
        Loop     = 1'b0;
        ready    = 1'b0;
        #2 Reset_b = 1'b1;
        tick();
        tick();

        // Reset values
        check_eq("rst_opvalid",  32'(op_if.OpValid),  32'd0);
        check_eq("rst_function", 32'(op_if.Function), 32'd3);
        check_eq("rst_data",     32'(op_if.Data),     32'd0);
        check_eq("rst_lastres",  32'(LastResult),     32'd0);
        check_eq("rst_stepidx",  32'(StepIdx),        32'd0);
        check_eq("rst_busy",     32'(Busy),           32'd0);
        check_eq("rst_done",     32'(Done),           32'd0);
        Reset_b = 1'b0;
        tick();

        // Three-op program, accumulator 0 -> 3 -> 6 -> 12
        load_entry(3'd0, 2'b00, 4'd3);
        load_entry(3'd1, 2'b01, 4'd2);
        load_entry(3'd2, 2'b10, 4'd1);
        ready = 1'b1;
        Count = 4'd3;
        Start = 1'b1;
        tick();                       // cycle 1: ISSUE step 0
        Start = 1'b0;
        check_eq("t1_valid0", 32'(op_if.OpValid),  32'd1);
        check_eq("t1_func0",  32'(op_if.Function), 32'd0);
        check_eq("t1_data0",  32'(op_if.Data),     32'd3);
        check_eq("t1_busy",   32'(Busy),           32'd1);
        tick();                       // cycle 2: WAIT
        check_eq("t1_wait_valid", 32'(op_if.OpValid),  32'd0);
        check_eq("t1_wait_func",  32'(op_if.Function), 32'd3);
        tick();                       // cycle 3: ISSUE step 1
        check_eq("t1_res0",  32'(LastResult),     32'd3);
        check_eq("t1_step1", 32'(StepIdx),        32'd1);
        check_eq("t1_func1", 32'(op_if.Function), 32'd1);
        check_eq("t1_data1", 32'(op_if.Data),     32'd2);
        tick();
        tick();                       // cycle 5: ISSUE step 2
        check_eq("t1_res1",  32'(LastResult), 32'd6);
        check_eq("t1_step2", 32'(StepIdx),    32'd2);
        tick();
        check_eq("t1_nodone6", 32'(Done), 32'd0);
        tick();                       // cycle 7: DONE
        check_eq("t1_done7",  32'(Done),       32'd1);
        check_eq("t1_res2",   32'(LastResult), 32'd12);
        check_eq("t1_busy7",  32'(Busy),       32'd0);
        tick();                       // back in IDLE
        check_eq("t1_done_pulse", 32'(Done),    32'd0);
        check_eq("t1_step_keep",  32'(StepIdx), 32'd2);

        // Back-pressure: valid op held stable while not ready
        ready = 1'b0;
        Count = 4'd1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("t2_valid", 32'(op_if.OpValid),  32'd1);
            check_eq("t2_func",  32'(op_if.Function), 32'd0);
            check_eq("t2_data",  32'(op_if.Data),     32'd3);
            check_eq("t2_step",  32'(StepIdx),        32'd0);
            tick();
        end
        ready = 1'b1;
        tick();                       // accepted -> WAIT
        check_eq("t2_wait_valid", 32'(op_if.OpValid), 32'd0);
        tick();
        check_eq("t2_done", 32'(Done),       32'd1);
        check_eq("t2_res",  32'(LastResult), 32'd15);
        tick();

        // Count == 0 finishes immediately without issuing
        acc_base = accepts;
        Count = 4'd0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check_eq("t3_done",  32'(Done),          32'd1);
        check_eq("t3_valid", 32'(op_if.OpValid), 32'd0);
        check_eq("t3_res",   32'(LastResult),    32'd15);
        tick();
        check_eq("t3_done_off", 32'(Done),            32'd0);
        check_eq("t3_no_ops",   accepts - acc_base,   32'd0);

        // Count clamps to DEPTH; Load/Start during the run are ignored
        for (int i = 0; i < 8; i++) load_entry(3'(i), 2'b00, 4'd1);
        acc_base = accepts;
        Count = 4'd12;
        Start = 1'b1;
        cyc   = 0;
        seen  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            cyc++;
            Start = 1'b0;
            Load  = 1'b0;
            if (cyc == 3) begin
                Load     = 1'b1;
                LoadAddr = 3'd7;
                LoadFunc = 2'b01;
                LoadData = 4'd0;
            end
            if (cyc == 6) Start = 1'b1;
            if (Done === 1'b1) seen = 1;
        end
        Start = 1'b0;
        Load  = 1'b0;
        check_eq("t5_seen_done", 32'(seen),          32'd1);
        check_eq("t5_cycles",    cyc,                32'd17);
        check_eq("t5_ops",       accepts - acc_base, 32'd8);
        check_eq("t5_res",       32'(LastResult),    32'd23);
        check_eq("t5_step",      32'(StepIdx),       32'd7);
        tick();

        // Load and Start together: first op sees the freshly written entry 0
        Load     = 1'b1;
        LoadAddr = 3'd0;
        LoadFunc = 2'b10;
        LoadData = 4'd2;
        Count    = 4'd1;
        Start    = 1'b1;
        tick();
        Load  = 1'b0;
        Start = 1'b0;
        check_eq("ls_func", 32'(op_if.Function), 32'd2);
        check_eq("ls_data", 32'(op_if.Data),     32'd2);
        tick();
        tick();
        check_eq("ls_done", 32'(Done),       32'd1);
        check_eq("ls_res",  32'(LastResult), 32'd92);
        tick();

        // Asynchronous reset between edges in WAIT
        Count = 4'd1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();                       // WAIT
        #3 Reset_b = 1'b1;
        #1;
        check_eq("t4_valid",   32'(op_if.OpValid),  32'd0);
        check_eq("t4_func",    32'(op_if.Function), 32'd3);
        check_eq("t4_data",    32'(op_if.Data),     32'd0);
        check_eq("t4_lastres", 32'(LastResult),     32'd0);
        check_eq("t4_step",    32'(StepIdx),        32'd0);
        check_eq("t4_busy",    32'(Busy),           32'd0);
        check_eq("t4_done",    32'(Done),           32'd0);
        #1 Reset_b = 1'b0;
        tick();
        ready = 1'b0;
        Count = 4'd1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check_eq("t4_prog_func", 32'(op_if.Function), 32'd3);
        check_eq("t4_prog_data", 32'(op_if.Data),     32'd0);
        ready = 1'b1;
        run_to_done(6, cyc);
        check_eq("t4_hold_res", 32'(LastResult), 32'd0);
        tick();

`ifdef ALU_SEQ_LOOP_EN
        // Looping run: 0,1,0,1 with no Done until Loop drops
        load_entry(3'd0, 2'b00, 4'd1);
        load_entry(3'd1, 2'b00, 4'd1);
        Loop  = 1'b1;
        Count = 4'd2;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq("t6_step",  32'(StepIdx),       32'(k % 2));
            check_eq("t6_valid", 32'(op_if.OpValid), 32'd1);
            check_eq("t6_nodone", 32'(Done),         32'd0);
            tick();
            check_eq("t6_nodone_w", 32'(Done), 32'd0);
            tick();
        end
        check_eq("t6_wrap", 32'(StepIdx), 32'd0);
        Loop = 1'b0;
        run_to_done(10, cyc);
        check_eq("t6_tail_cycles", cyc,             32'd4);
        check_eq("t6_res",         32'(LastResult), 32'd6);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
